sd_crg_gen: RTL and testbench
=============================

Name: sd_crg_gen

Overview:
- Parametrised SD host clock rate generator. It divides the system clock into sd_clk_out, with divider width set by parameter.
- Adds a clean stop/start handshake: the clock always parks low, with no runt phases.
- Divider changes take effect only at period boundaries.
- Provides exact 1us and 1ms timebase pulses to the SD command/data engines, plus an optional ms-granular timeout counter.

Parameters:
- CLK_RATE, 50000000, system clock in Hz. Must be a non-zero multiple of 1000000.
- DIV_W, 8, width of the divider value.
- TO_W, 10, width of the timeout load value, in ms.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clkdiv_val  in  DIV_W  half-period minus 1, in clk cycles
- clk_en  in  1  level; 1 = run SD clock, 0 = park low
- clk_running  out  1  1 while SD clock is toggling
- sd_clk_out  out  1  SD card clock
- sd_clk_rising  out  1  strobe in the cycle before sd_clk_out rises
- sd_clk_falling  out  1  strobe in the cycle before sd_clk_out falls
- us_pulse  out  1  one-cycle pulse every 1us
- ms_pulse  out  1  one-cycle pulse every 1ms
- to_start  in  1  load timeout (optional feature)
- to_ms  in  TO_W  timeout length in ms (optional feature)
- to_expired  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset:
  - State STOP.
  - sd_clk_out=0, clk_running=0, no strobes.
  - cnt=clkdiv_val, cur_div=clkdiv_val.
  - us_pulse=0, ms_pulse=0; timebase counters cleared.
  - to_expired=0, remaining=0.
- Divider:
  - Each half-period is cur_div+1 clk cycles. cur_div=0 gives sd_clk = clk/2; maximum is 2^DIV_W half-period cycles.
  - cnt decrements each RUN cycle. At cnt==0, sd_clk_out toggles on the next edge and cnt reloads.
- Strobes (combinational, RUN state only):
  - sd_clk_rising = (cnt==0) && !sd_clk_out && clk_en.
  - sd_clk_falling = (cnt==0) && sd_clk_out.
  - Never both in the same cycle.
- cur_div latching:
  - Latched from clkdiv_val on each sd_clk_falling cycle, and every cycle in STOP.
  - Both phases of a period therefore use the same divider.
  - cnt reloads with the new value at the falling toggle.
  - At the rising toggle, cnt reloads with cur_div.
- FSM STOP -> RUN:
  - Taken when clk_en=1 in STOP.
  - Next cycle: clk_running=1, cnt=cur_div counting down, sd_clk_out=0.
  - First sd_clk_rising occurs cur_div+1 cycles after RUN entry, giving a full-length low phase.
- FSM RUN -> STOP:
  - Taken when cnt==0 && !sd_clk_out && !clk_en.
  - The rise is suppressed: no strobe, sd_clk_out stays 0, clk_running=0 next cycle.
  - If clk_en drops during the high phase, the falling edge still completes normally, then the low phase runs full length before STOP.
  - clk_en reasserted before the stop point means the clock never stops.
- Reset mid-operation: immediate return to reset state on the next edge, even with sd_clk_out high.
- Timebase:
  - US_DIV = CLK_RATE/1000000.
  - us counter runs 0..US_DIV-1 and wraps.
  - us_pulse is registered: high for 1 cycle in the cycle after the counter equals US_DIV-1. The first pulse is in cycle US_DIV+1 (cycle 1 = first cycle with reset low); period is exactly US_DIV.
  - ms counter counts us wraps 0..999.
  - ms_pulse is high in the same cycle as every 1000th us_pulse. Period is exactly 1000*US_DIV cycles.
  - Timebase is independent of clk_en and FSM state.

Optional Feature:
- Macro: SD_CRG_TIMEOUT_EN.
- With the macro:
  - to_start=1 loads remaining=to_ms and clears to_expired.
  - Each ms_pulse with remaining>0 decrements remaining; to_expired is set when remaining goes 1->0.
  - to_ms=0 sets to_expired the cycle after to_start.
  - to_start coincident with ms_pulse: the load wins and no decrement occurs.
  - to_expired is sticky until the next to_start or reset.
  - Resolution: expiry occurs between to_ms-1 and to_ms ms after start.
- Without the macro:
  - Ports remain present; to_start and to_ms are ignored.
  - to_expired is constant 0 and no counter logic is generated.

Test Plan:
- Reset, clkdiv_val=3, clk_en=1 -> clk_running=1 after 1 cycle; sd_clk_out has period 8 cycles, 50% duty; each rising/falling strobe is 1 cycle, directly preceding its edge.
- clkdiv_val=0 -> sd_clk_out toggles every cycle; strobes alternate every cycle.
- Running at div=3, change clkdiv_val to 1 mid-high-phase -> current high phase stays 4 cycles; all subsequent phases are 2 cycles; no short phase.
- clk_en=0 asserted mid-high-phase at div=3 -> falling edge completes, low phase lasts 4 cycles, no rising strobe, sd_clk_out parks 0, clk_running=0. Re-enable -> first rise after 4 low cycles.
- CLK_RATE=50000000 -> first us_pulse in cycle 51, then every 50 cycles; ms_pulse every 50000 cycles, coincident with the 1000th us_pulse.
- SD_CRG_TIMEOUT_EN defined:
  - to_ms=3 -> to_expired set on the 3rd ms_pulse after to_start and stays high.
  - to_start on the same cycle as ms_pulse -> reload with no decrement.
  - to_ms=0 -> expired 1 cycle after start.

Source files
------------

// File: rtl/sd_crg_gen.sv
// sd_crg_gen: SD host clock rate generator with glitch-free stop/start,
// period-aligned divider updates and exact 1us / 1ms timebase pulses.
// Optional ms-granular timeout counter is enabled by defining SD_CRG_TIMEOUT_EN;
// without it the to_* inputs are ignored and to_expired is tied low.
module sd_crg_gen #(
  parameter int unsigned CLK_RATE = 50000000,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned TO_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] clkdiv_val,
  input  logic             clk_en,
  output logic             clk_running,
  output logic             sd_clk_out,
  output logic             sd_clk_rising,
  output logic             sd_clk_falling,
  output logic             us_pulse,
  output logic             ms_pulse,
  input  logic             to_start,
  input  logic [TO_W-1:0]  to_ms,
  output logic             to_expired
);

  localparam int unsigned US_DIV = CLK_RATE / 1000000;
  localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W   = 10;
  localparam int unsigned MS_DIV = 1000;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] cur_div_nxt;
  logic             sd_clk_nxt;
  logic             running_nxt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, half-period counter, divider latch and edge strobes
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_div_nxt    = cur_div;
    sd_clk_nxt     = sd_clk_out;
    running_nxt    = clk_running;
    sd_clk_rising  = 1'b0;
    sd_clk_falling = 1'b0;
    case (state)
      ST_STOP: begin
        // Parked: track the requested divider so the first low phase is full length
        cnt_nxt     = clkdiv_val;
        cur_div_nxt = clkdiv_val;
        sd_clk_nxt  = 1'b0;
        if (clk_en) begin
          state_nxt   = ST_RUN;
          running_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - DIV_W'(1);
        if (cnt_zero) begin
          if (sd_clk_out) begin
            // Falling toggle is the period boundary: pick up a new divider here
            sd_clk_falling = 1'b1;
            sd_clk_nxt     = 1'b0;
            cur_div_nxt    = clkdiv_val;
            cnt_nxt        = clkdiv_val;
          end else if (clk_en) begin
            sd_clk_rising = 1'b1;
            sd_clk_nxt    = 1'b1;
            cnt_nxt       = cur_div;
          end else begin
            // Suppress the rise and park low after a complete low phase
            state_nxt   = ST_STOP;
            running_nxt = 1'b0;
            cnt_nxt     = clkdiv_val;
            cur_div_nxt = clkdiv_val;
          end
        end
      end
      default: begin
        state_nxt = ST_STOP;
      end
    endcase
  end

  // Divider datapath and registered clock outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= clkdiv_val;
      cur_div     <= clkdiv_val;
      sd_clk_out  <= 1'b0;
      clk_running <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      cur_div     <= cur_div_nxt;
      sd_clk_out  <= sd_clk_nxt;
      clk_running <= running_nxt;
    end
  end

  logic [US_W-1:0] us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic            us_wrap;
  logic            ms_wrap;

  assign us_wrap = (us_cnt == US_W'(US_DIV - 1));
  assign ms_wrap = (ms_cnt == MS_W'(MS_DIV - 1));

  // Free-running 1us / 1ms timebase, independent of the SD clock FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      us_cnt   <= '0;
      ms_cnt   <= '0;
      us_pulse <= 1'b0;
      ms_pulse <= 1'b0;
    end else begin
      us_cnt   <= us_wrap ? '0 : us_cnt + US_W'(1);
      us_pulse <= us_wrap;
      ms_pulse <= us_wrap && ms_wrap;
      if (us_wrap) begin
        ms_cnt <= ms_wrap ? '0 : ms_cnt + MS_W'(1);
      end
    end
  end

`ifdef SD_CRG_TIMEOUT_EN
  logic [TO_W-1:0] remaining;

  // Millisecond timeout: load beats a coincident decrement, expiry is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining  <= '0;
      to_expired <= 1'b0;
    end else if (to_start) begin
      remaining  <= to_ms;
      to_expired <= (to_ms == '0);
    end else if (ms_pulse && (remaining != '0)) begin
      remaining <= remaining - TO_W'(1);
      if (remaining == TO_W'(1)) begin
        to_expired <= 1'b1;
      end
    end
  end
`else
  logic unused_to;

  assign unused_to  = ^{to_start, to_ms};
  assign to_expired = 1'b0;
`endif

endmodule

// File: tb/tb_sd_crg_gen.sv
// tb_sd_crg_gen: scoreboard bench for sd_crg_gen. Stimulus pushes expected
// events (cycle + kind) into a sorted queue; a negedge monitor pops and compares.
module tb_sd_crg_gen;

  localparam int K_RS   = 0;
  localparam int K_FS   = 1;
  localparam int K_UP   = 2;
  localparam int K_DN   = 3;
  localparam int K_RON  = 4;
  localparam int K_ROFF = 5;
  localparam int K_US   = 6;
  localparam int K_MS   = 7;
  localparam int K_TO   = 8;
  localparam int K_TF   = 9;
  localparam int NK     = 10;

  localparam logic [NK-1:0] SD_KINDS = 10'b00_0011_1111;
  localparam logic [NK-1:0] TB_KINDS = 10'b11_1100_0000;

  typedef struct {
    int            cyc;
    logic [NK-1:0] kinds;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [7:0] clkdiv_val;
  logic       clk_en;
  logic       clk_running;
  logic       sd_clk_out;
  logic       sd_clk_rising;
  logic       sd_clk_falling;
  logic       us_pulse;
  logic       ms_pulse;
  logic       to_start;
  logic [9:0] to_ms;
  logic       to_expired;
  logic       aux_expired;

  int            now = 0;
  int            total = 0;
  int            bad = 0;
  logic [NK-1:0] chk_mask = '0;
  ev_t           exp_q[$];

  sd_crg_gen u_dut (
    .clk            (clk),
    .reset          (reset),
    .clkdiv_val     (clkdiv_val),
    .clk_en         (clk_en),
    .clk_running    (clk_running),
    .sd_clk_out     (sd_clk_out),
    .sd_clk_rising  (sd_clk_rising),
    .sd_clk_falling (sd_clk_falling),
    .us_pulse       (us_pulse),
    .ms_pulse       (ms_pulse),
    .to_start       (to_start),
    .to_ms          (to_ms),
    .to_expired     (to_expired)
  );

`ifdef SD_CRG_TIMEOUT_EN
  // 1 MHz instance: 1 ms = 1000 cycles keeps the timeout scenarios short
  logic [7:0] aux_div;
  logic       aux_running;
  logic       aux_sd_clk;
  logic       aux_rising;
  logic       aux_falling;
  logic       aux_us;
  logic       aux_ms;

  assign aux_div = 8'd0;

  sd_crg_gen #(.CLK_RATE(1000000)) u_to (
    .clk            (clk),
    .reset          (reset),
    .clkdiv_val     (aux_div),
    .clk_en         (1'b0),
    .clk_running    (aux_running),
    .sd_clk_out     (aux_sd_clk),
    .sd_clk_rising  (aux_rising),
    .sd_clk_falling (aux_falling),
    .us_pulse       (aux_us),
    .ms_pulse       (aux_ms),
    .to_start       (to_start),
    .to_ms          (to_ms),
    .to_expired     (aux_expired)
  );
`else
  assign aux_expired = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index used by both stimulus and monitor
  always @(posedge clk) now <= now + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", now);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, now, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int c, input int k);
    ev_t e;
    int  idx;
    e.cyc      = c;
    e.kinds    = '0;
    e.kinds[k] = 1'b1;
    idx = exp_q.size();
    while (idx > 0 && exp_q[idx-1].cyc > c) idx--;
    exp_q.insert(idx, e);
  endtask

  task automatic run_to(input int c);
    while (now < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] div, output int a);
    chk_mask   = '0;
    clk_en     = 1'b0;
    to_start   = 1'b0;
    clkdiv_val = div;
    reset      = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    a     = now;
    chk("rst_sd_clk_out", int'(sd_clk_out), 0);
    chk("rst_clk_running", int'(clk_running), 0);
    chk("rst_rising", int'(sd_clk_rising), 0);
    chk("rst_falling", int'(sd_clk_falling), 0);
    chk("rst_us_pulse", int'(us_pulse), 0);
    chk("rst_ms_pulse", int'(ms_pulse), 0);
    chk("rst_to_expired", int'(to_expired), 0);
  endtask

  logic [NK-1:0] obs;
  logic [NK-1:0] expm;
  logic          prev_sd  = 1'b0;
  logic          prev_run = 1'b0;
  logic          prev_to  = 1'b0;

  // Monitor: gather observed events this cycle and compare with queued expectations
  always @(negedge clk) begin
    obs         = '0;
    obs[K_RS]   = sd_clk_rising;
    obs[K_FS]   = sd_clk_falling;
    obs[K_UP]   = sd_clk_out & ~prev_sd;
    obs[K_DN]   = ~sd_clk_out & prev_sd;
    obs[K_RON]  = clk_running & ~prev_run;
    obs[K_ROFF] = ~clk_running & prev_run;
    obs[K_US]   = us_pulse;
    obs[K_MS]   = ms_pulse;
    obs[K_TO]   = aux_expired & ~prev_to;
    obs[K_TF]   = ~aux_expired & prev_to;
    obs         = obs & chk_mask;
    expm        = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= now) begin
      if (exp_q[0].cyc < now) begin
        total++;
        bad++;
        $display("FAIL stale_expect cycle=%0d got=none expected=%b@%0d", now, exp_q[0].kinds, exp_q[0].cyc);
      end else begin
        expm = expm | exp_q[0].kinds;
      end
      void'(exp_q.pop_front());
    end
    if ((obs | expm) != '0) begin
      total++;
      if (obs != expm) begin
        bad++;
        $display("FAIL events cycle=%0d got=%b expected=%b", now, obs, expm);
      end
    end
    prev_sd  = sd_clk_out;
    prev_run = clk_running;
    prev_to  = aux_expired;
  end

  initial begin
    int a;
    reset      = 1'b1;
    clk_en     = 1'b0;
    clkdiv_val = 8'd0;
    to_start   = 1'b0;
    to_ms      = 10'd0;

    // div=3: period 8, 50% duty; a brief clk_en drop that recovers never stops the clock
    do_reset(8'd3, a);
    chk_mask = SD_KINDS;
    clk_en   = 1'b1;
    expect_ev(a + 1, K_RON);
    for (int j = 0; j < 3; j++) begin
      expect_ev(a + 4 + 8*j, K_RS);
      expect_ev(a + 5 + 8*j, K_UP);
      expect_ev(a + 8 + 8*j, K_FS);
      expect_ev(a + 9 + 8*j, K_DN);
    end
    run_to(a + 14);
    clk_en = 1'b0;
    run_to(a + 18);
    clk_en = 1'b1;
    run_to(a + 26);

    // div=0: toggles every cycle, strobes alternate
    do_reset(8'd0, a);
    chk_mask = SD_KINDS;
    clk_en   = 1'b1;
    expect_ev(a + 1, K_RON);
    for (int j = 0; j < 6; j++) expect_ev(a + 1 + 2*j, K_RS);
    for (int j = 0; j < 5; j++) begin
      expect_ev(a + 2 + 2*j, K_FS);
      expect_ev(a + 2 + 2*j, K_UP);
      expect_ev(a + 3 + 2*j, K_DN);
    end
    run_to(a + 12);

    // div 3 -> 1 during high phase: high stays 4, then 2-cycle phases
    do_reset(8'd3, a);
    chk_mask = SD_KINDS;
    clk_en   = 1'b1;
    expect_ev(a + 1, K_RON);
    expect_ev(a + 4, K_RS);
    expect_ev(a + 5, K_UP);
    expect_ev(a + 8, K_FS);
    expect_ev(a + 9, K_DN);
    for (int j = 0; j < 3; j++) begin
      expect_ev(a + 10 + 4*j, K_RS);
      expect_ev(a + 11 + 4*j, K_UP);
      expect_ev(a + 12 + 4*j, K_FS);
      expect_ev(a + 13 + 4*j, K_DN);
    end
    run_to(a + 6);
    clkdiv_val = 8'd1;
    run_to(a + 22);

    // clk_en drop in high phase: fall completes, full low phase, park, restart
    do_reset(8'd3, a);
    chk_mask = SD_KINDS;
    clk_en   = 1'b1;
    expect_ev(a + 1, K_RON);
    expect_ev(a + 4, K_RS);
    expect_ev(a + 5, K_UP);
    expect_ev(a + 8, K_FS);
    expect_ev(a + 9, K_DN);
    expect_ev(a + 12, K_RS);
    expect_ev(a + 13, K_UP);
    expect_ev(a + 16, K_FS);
    expect_ev(a + 17, K_DN);
    expect_ev(a + 21, K_ROFF);
    expect_ev(a + 26, K_RON);
    expect_ev(a + 29, K_RS);
    expect_ev(a + 30, K_UP);
    expect_ev(a + 33, K_FS);
    expect_ev(a + 34, K_DN);
    run_to(a + 14);
    clk_en = 1'b0;
    run_to(a + 23);
    chk("park_sd_clk_out", int'(sd_clk_out), 0);
    chk("park_clk_running", int'(clk_running), 0);
    chk("park_rising", int'(sd_clk_rising), 0);
    run_to(a + 25);
    clk_en = 1'b1;
    run_to(a + 35);

    // Reset while sd_clk_out is high forces it low on the next edge
    do_reset(8'd3, a);
    chk_mask = SD_KINDS;
    clk_en   = 1'b1;
    expect_ev(a + 1, K_RON);
    expect_ev(a + 4, K_RS);
    expect_ev(a + 5, K_UP);
    expect_ev(a + 7, K_DN);
    expect_ev(a + 7, K_ROFF);
    expect_ev(a + 8, K_RON);
    expect_ev(a + 11, K_RS);
    expect_ev(a + 12, K_UP);
    run_to(a + 6);
    reset = 1'b1;
    run_to(a + 7);
    reset = 1'b0;
    run_to(a + 13);

    // Timebase at 50 MHz: us at cycle 51 then every 50, ms at cycle 50001
    do_reset(8'd7, a);
    chk_mask = TB_KINDS;
    clk_en   = 1'b1;
    for (int j = 0; j < 1000; j++) expect_ev(a + 50 + 50*j, K_US);
    expect_ev(a + 50000, K_MS);
`ifdef SD_CRG_TIMEOUT_EN
    // aux instance ms pulses land on cycles a+1000*n
    expect_ev(a + 4001, K_TO);
    expect_ev(a + 5501, K_TF);
    expect_ev(a + 8001, K_TO);
    expect_ev(a + 9201, K_TF);
    expect_ev(a + 9301, K_TO);
    run_to(a + 1500);
    to_ms    = 10'd3;
    to_start = 1'b1;
    run_to(a + 1501);
    to_start = 1'b0;
    run_to(a + 4500);
    chk("to_sticky_a", int'(aux_expired), 1);
    run_to(a + 5400);
    chk("to_sticky_b", int'(aux_expired), 1);
    run_to(a + 5500);
    to_ms    = 10'd4;
    to_start = 1'b1;
    run_to(a + 5501);
    to_start = 1'b0;
    run_to(a + 6000);
    to_ms    = 10'd2;
    to_start = 1'b1;
    run_to(a + 6001);
    to_start = 1'b0;
    run_to(a + 9200);
    to_ms    = 10'd5;
    to_start = 1'b1;
    run_to(a + 9201);
    to_start = 1'b0;
    run_to(a + 9300);
    to_ms    = 10'd0;
    to_start = 1'b1;
    run_to(a + 9301);
    to_start = 1'b0;
`else
    run_to(a + 100);
    to_ms    = 10'd0;
    to_start = 1'b1;
    run_to(a + 101);
    to_start = 1'b0;
    chk("to_disabled_a", int'(to_expired), 0);
    run_to(a + 102);
    chk("to_disabled_b", int'(to_expired), 0);
`endif
    run_to(a + 50001);

    chk("leftover_expect", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
